// File: rtl/audio_pkg.sv
// Shared constants and types for the codec ADC deserializer.
package audio_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 6;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Serial format select
  localparam logic FMT_I2S = 1'b0;
  localparam logic FMT_LJ  = 1'b1;

  // Channel encoding matches the codec frame clock level
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // First state of a channel slot: I2S skips the boundary bit, LJ shifts it in.
  function automatic state_t slot_start_state(input logic fmt);
    case (fmt)
      FMT_I2S: return DELAY;
      FMT_LJ:  return SHIFT;
      default: return ALIGN;
    endcase
  endfunction

endpackage

// File: rtl/audio_pin_sync.sv
// Synchronizer for the three codec pins plus a bit-clock rising-edge pulse.
module audio_pin_sync
  import audio_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic       state_clk,
  input  logic       reset,
  input  logic [2:0] pins,        // {bclk, lrck, dat}
  output logic       lrck_sync,
  output logic       dat_sync,
  output logic       bclk_rise
);

  logic [2:0] stage_q [STAGES];
  logic       bclk_prev;

  // Flop chain on every pin; the bclk tap after the chain feeds the edge detector
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge state_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      bclk_prev <= 1'b0;
    end else begin
      stage_q[0] <= pins;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      bclk_prev <= stage_q[STAGES-1][2];
    end
  end

  assign lrck_sync = stage_q[STAGES-1][1];
  assign dat_sync  = stage_q[STAGES-1][0];
  assign bclk_rise = stage_q[STAGES-1][2] & ~bclk_prev;

endmodule

// File: rtl/audio_adc_deserializer.sv
// Codec ADC serial-to-parallel converter: aligns to the frame clock, captures
// SAMPLE_W bits per channel and publishes a stereo pair once per good frame.
module audio_adc_deserializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = audio_pkg::SAMPLE_W,
  parameter int SYNC_STAGES = audio_pkg::SYNC_STAGES,
  parameter int CNT_W       = audio_pkg::CNT_W
) (
  input  logic                state_clk,
  input  logic                reset,
  input  logic                adc_bclk,
  input  logic                adc_lrck,
  input  logic                adc_dat,
  input  logic                fmt_lj,
  output logic [SAMPLE_W-1:0] audio_left,
  output logic [SAMPLE_W-1:0] audio_right,
  output logic                sample_valid,
  output logic                lr_out,
  output logic                frame_err
);

  logic lrck_s, dat_s, bclk_rise;

  audio_pin_sync #(.STAGES(SYNC_STAGES)) u_pin_sync (
    .state_clk (state_clk),
    .reset     (reset),
    .pins      ({adc_bclk, adc_lrck, adc_dat}),
    .lrck_sync (lrck_s),
    .dat_sync  (dat_s),
    .bclk_rise (bclk_rise)
  );

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [SAMPLE_W-1:0] shreg, shreg_next;
  logic [SAMPLE_W-1:0] left_hold, left_hold_next;
  logic                chan, chan_next;
  logic                left_ok, left_ok_next;
  logic                lr_q, lr_q_next;
  logic [SAMPLE_W-1:0] audio_left_next, audio_right_next;
  logic                valid_next, err_next;
  logic [SAMPLE_W-1:0] shifted;
  logic                boundary;

  assign shifted  = {shreg[SAMPLE_W-2:0], dat_s};
  assign boundary = bclk_rise && (lrck_s != lr_q);
  assign lr_out   = lr_q;

  // State, datapath and output registers
  always_ff @(posedge state_clk or negedge reset) begin
    if (!reset) begin
      state        <= ALIGN;
      cnt          <= '0;
      shreg        <= '0;
      left_hold    <= '0;
      chan         <= CH_LEFT;
      left_ok      <= 1'b0;
      lr_q         <= 1'b0;
      audio_left   <= '0;
      audio_right  <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      shreg        <= shreg_next;
      left_hold    <= left_hold_next;
      chan         <= chan_next;
      left_ok      <= left_ok_next;
      lr_q         <= lr_q_next;
      audio_left   <= audio_left_next;
      audio_right  <= audio_right_next;
      sample_valid <= valid_next;
      frame_err    <= err_next;
    end
  end

  // Next-state logic: slot alignment, bit capture, channel completion and pairing
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // a missing default in combinational logic infers a latch.
    state_next       = state;
    cnt_next         = cnt;
    shreg_next       = shreg;
    left_hold_next   = left_hold;
    chan_next        = chan;
    left_ok_next     = left_ok;
    lr_q_next        = lr_q;
    audio_left_next  = audio_left;
    audio_right_next = audio_right;
    valid_next       = 1'b0;
    err_next         = 1'b0;

    if (bclk_rise) begin
      lr_q_next = lrck_s;

      if (boundary) begin
        // A slot that ends before all sample bits arrived is dropped
        if (state == DELAY || state == SHIFT) err_next = 1'b1;

        // ALIGN only locks on a boundary into the left channel
        if (state != ALIGN || lrck_s == CH_LEFT) begin
          chan_next = lrck_s;
          // A new left slot opens a new frame: any earlier left is stale
          if (lrck_s == CH_LEFT) left_ok_next = 1'b0;
          state_next = slot_start_state(fmt_lj);
          if (state_next == SHIFT) begin
            shreg_next = shifted;
            cnt_next   = CNT_W'(1);
          end else begin
            cnt_next   = '0;
          end
        end
      end else begin
        case (state)
          DELAY: begin
            // Second edge of an I2S slot carries the MSB
            state_next = SHIFT;
            shreg_next = shifted;
            cnt_next   = CNT_W'(1);
          end
          SHIFT: begin
            shreg_next = shifted;
            cnt_next   = cnt + CNT_W'(1);
            if (cnt_next == CNT_W'(SAMPLE_W)) begin
              state_next = HOLD;
              if (chan == CH_LEFT) begin
                left_hold_next = shifted;
                left_ok_next   = 1'b1;
              end else if (left_ok) begin
                audio_left_next  = left_hold;
                audio_right_next = shifted;
                valid_next       = 1'b1;
                left_ok_next     = 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/audio_adc_deserializer.md
Name: audio_adc_deserializer

Overview:
Receives serial audio from the codec ADC (codec is bit-clock/frame master) and delivers parallel signed 16-bit left/right samples to the 27-bit IIR filter stage. All codec pins are oversampled in the fast state_clk domain. The block emits a one-cycle sample_valid per stereo frame and a clean frame clock (lr_out) for the filter's lr_clk input.

Parameters:
SAMPLE_W, 16, bits captured per channel, MSB-first; later bits in a slot are ignored
SYNC_STAGES, 2, flip-flop stages on each codec input (minimum 2)
CNT_W, 6, bit-counter width; counts up to 63 bits per slot

Ports:
state_clk  in  1  system clock; must run at least 8x the codec bit clock
reset  in  1  asynchronous, active-low reset
adc_bclk  in  1  codec bit clock, asynchronous
adc_lrck  in  1  codec frame clock, asynchronous; 0 = left, 1 = right
adc_dat  in  1  codec serial data, asynchronous
fmt_lj  in  1  0 = I2S (one-bit delay), 1 = left-justified; quasi-static
audio_left  out  SAMPLE_W  signed left sample
audio_right  out  SAMPLE_W  signed right sample
sample_valid  out  1  one-cycle pulse; both sample outputs updated together
lr_out  out  1  synchronized frame clock, sampled at bit-clock rising edges
frame_err  out  1  one-cycle pulse when a channel slot ends early

Behaviour:
- Reset (reset low, asynchronous): all outputs are 0, the state is ALIGN, and the synchronizers and counter clear.
- Input path:
  - adc_bclk, adc_lrck and adc_dat each pass through SYNC_STAGES flops.
  - bclk_rise is a one-cycle pulse when the synchronized bclk goes 0 to 1.
  - lrck and dat are sampled only on bclk_rise cycles; the sampled lrck is lr_q.
- Slot boundary: on a bclk_rise cycle where the sampled lrck differs from lr_q. lr_out equals lr_q.
- FSM states:
  - ALIGN: wait for a boundary into left (lrck 1 to 0); then go to DELAY if fmt_lj=0, or to SHIFT with this bit taken as the MSB if fmt_lj=1.
  - DELAY: the bit at the boundary edge is discarded; the next bclk_rise goes to SHIFT.
  - SHIFT: each bclk_rise shifts dat into the channel shift register and increments the counter. When the count reaches SAMPLE_W, go to HOLD.
  - HOLD: ignore further bits until the next boundary, then start the other channel (DELAY or SHIFT per fmt_lj).
- Boundary during DELAY or SHIFT (count < SAMPLE_W):
  - pulse frame_err, discard the channel;
  - if it was the left channel, also discard the frame;
  - start the new channel normally; outputs keep their prior values.
- Completion:
  - Left completing latches a left holding register.
  - Right completing updates audio_left (from the holding register) and audio_right on the next state_clk edge, with sample_valid high for exactly that cycle.
  - Latency: 1 state_clk after the bclk_rise cycle that carries the right LSB.
- No pairing across frames: sample_valid requires a valid left followed by a valid right in the same frame.
- fmt_lj change: takes effect at the next boundary.
- Reset mid-frame: outputs return to 0 and the block realigns at the next left boundary.
- Arithmetic: none. The first captured bit is the sign bit, and no sign extension is needed.

Decomposition:
- Shared package audio_pkg holds SAMPLE_W, the FSM state encoding (ALIGN, DELAY, SHIFT, HOLD) and the format constants FMT_I2S=0 and FMT_LJ=1.
- One sub-module, audio_pin_sync: a SYNC_STAGES synchronizer for a 3-bit bus {bclk, lrck, dat}, plus the bclk rising-edge pulse.
- The top level holds the FSM, counter, shift register and output registers.

Test Plan:
- I2S, 32-bit slots, left=0x1234, right=0xFEDC -> audio_left=0x1234, audio_right=0xFEDC, one sample_valid per frame, and lr_out follows lrck.
- fmt_lj=1, left=0x8000, right=0x7FFF -> audio_left=0x8000, audio_right=0x7FFF, with no one-bit shift error.
- Reset released mid right slot, then two full frames (0x0001/0x0002, 0x0003/0x0004) -> no valid before the first full left slot, then exactly two pulses with the correct values.
- Left slot truncated to 10 bits by an early lrck edge -> frame_err pulses once, no sample_valid for that frame, outputs unchanged, and the next frame is decoded correctly.
- 24-bit slots with data 0xABCD followed by 8 junk bits -> audio outputs are 0xABCD and the junk is ignored.
- reset asserted for 3 cycles mid-shift -> all outputs are 0 immediately (asynchronously), and decoding resumes at the next left boundary with no spurious valid.
